// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types, defaults and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // One extra bit over $clog2 so the counter can hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: single-bit combinational subtract cell (a - b - bin).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated toward the next more-significant bit.
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial A - B with a registered borrow chain.
// Optional feature macro: SERIAL_SUB_OVFL_EN adds a registered signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVFL_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [CW-1:0]    cnt;
  logic             borrow_q;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;
  logic             accept;

`ifdef SERIAL_SUB_OVFL_EN
  logic a_msb;
  logic b_msb;
`endif

  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
  assign accept   = start && ((state == IDLE) || (state == DONE));

  // State register; reset wins over any start seen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; DONE accepts a new start directly so there is no idle bubble.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? SHIFT : IDLE;
      SHIFT:   next_state = (cnt == LAST_CNT) ? DONE : SHIFT;
      DONE:    next_state = start ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, one bit per cycle through the cell, results loaded only on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      cnt        <= '0;
      borrow_q   <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVFL_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else if (accept) begin
      sa       <= a;
      sb       <= b;
      sd       <= '0;
      cnt      <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVFL_EN
      a_msb    <= a[WIDTH-1];
      b_msb    <= b[WIDTH-1];
`endif
    end else if (state == SHIFT) begin
      sa       <= sa >> 1;
      sb       <= sb >> 1;
      sd       <= {cell_d, sd[WIDTH-1:1]};
      borrow_q <= cell_bout;
      cnt      <= cnt + 1'b1;
      if (last_bit) begin
        diff       <= {cell_d, sd[WIDTH-1:1]};
        borrow_out <= cell_bout;
`ifdef SERIAL_SUB_OVFL_EN
        overflow   <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed scoreboard bench for serial_subtractor (WIDTH=8 and WIDTH=4).
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       overflow;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] diff4;
  logic       borrow4;
  logic       overflow4;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc;
  int   done_cyc;
  int   prev_done;
  exp_t q8[$];
  exp_t q4[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVFL_EN
    ,
    .overflow   (overflow)
`endif
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (borrow4)
`ifdef SERIAL_SUB_OVFL_EN
    ,
    .overflow   (overflow4)
`endif
  );

`ifndef SERIAL_SUB_OVFL_EN
  assign overflow  = 1'b0;
  assign overflow4 = 1'b0;
`endif

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model8(input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e.diff   = av - bv;
    e.borrow = (av < bv);
    e.ovf    = (av[7] != bv[7]) && (e.diff[7] != av[7]);
    return e;
  endfunction

  function automatic exp_t model4(input logic [3:0] av, input logic [3:0] bv);
    exp_t e;
    logic [3:0] d4;
    d4       = av - bv;
    e.diff   = {4'h0, d4};
    e.borrow = (av < bv);
    e.ovf    = (av[3] != bv[3]) && (d4[3] != av[3]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input bit push);
    start = 1'b1;
    a     = av;
    b     = bv;
    if (push) q8.push_back(model8(av, bv));
    tick();
    start_cyc = cyc;
    start = 1'b0;
    a     = $urandom_range(255, 0);
    b     = $urandom_range(255, 0);
  endtask

  task automatic waitDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    done_cyc = cyc;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (q8.size() == 0) begin
      chk({tag, "_queue"}, 32'(q8.size()), 32'd1);
    end else begin
      e = q8.pop_front();
      chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
      chk({tag, "_borrow"}, 32'(borrow_out), 32'(e.borrow));
`ifdef SERIAL_SUB_OVFL_EN
      chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
`endif
    end
  endtask

  // Directed sequence: reset, basic ops, ignored start, DONE restart, reset abort, WIDTH=4 sweep.
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end
    chk("idle_diff", 32'(diff), 32'd0);
    chk("idle_borrow", 32'(borrow_out), 32'd0);
    chk("idle_ovf", 32'(overflow), 32'd0);

    applyStimulus(8'h05, 8'h03, 1'b1);
    chk("t1_busy", 32'(busy), 32'd1);
    waitDone("t1");
    chk("t1_latency", 32'(done_cyc - start_cyc), 32'd8);
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    checkOutput("t1");
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_hold", 32'(diff), 32'h02);

    applyStimulus(8'h03, 8'h05, 1'b1);
    chk("t2_hold_prev", 32'(diff), 32'h02);
    waitDone("t2");
    checkOutput("t2");

    applyStimulus(8'h80, 8'h01, 1'b1);
    waitDone("t3");
    checkOutput("t3");

    applyStimulus(8'h10, 8'h01, 1'b1);
    tick();
    tick();
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    tick();
    start = 1'b0;
    waitDone("t4");
    chk("t4_latency", 32'(done_cyc - start_cyc), 32'd8);
    checkOutput("t4");
    prev_done = done_cyc;
    applyStimulus(8'h00, 8'h01, 1'b1);
    chk("t5_no_bubble", 32'(busy), 32'd1);
    waitDone("t5");
    chk("t5_spacing", 32'(done_cyc - prev_done), 32'd9);
    checkOutput("t5");

    applyStimulus(8'hAA, 8'h55, 1'b0);
    tick();
    tick();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rst_no_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        exp_t e;
        bit   seen;
        start4 = 1'b1;
        a4     = i[3:0];
        b4     = j[3:0];
        q4.push_back(model4(i[3:0], j[3:0]));
        tick();
        start4 = 1'b0;
        seen   = 1'b0;
        for (int k = 0; k < 20; k++) begin
          tick();
          if (done4) begin
            seen = 1'b1;
            break;
          end
        end
        chk("w4_done_seen", 32'(seen), 32'd1);
        e = q4.pop_front();
        chk("w4_diff", 32'(diff4), 32'(e.diff));
        chk("w4_borrow", 32'(borrow4), 32'(e.borrow));
`ifdef SERIAL_SUB_OVFL_EN
        chk("w4_ovf", 32'(overflow4), 32'(e.ovf));
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
